// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write FIFO, runtime baud divisor and per-frame
// configuration (5-8 data bits, none/even/odd parity, 1-2 stop bits, line break).
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int DIV_W = 16
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [DIV_W-1:0]         baud_div,
  input  logic [1:0]               cfg_bits,
  input  logic [1:0]               cfg_parity,
  input  logic                     cfg_stop2,
  input  logic                     cfg_break,
  input  logic                     wr_valid,
  input  logic [7:0]               wr_data,
  output logic                     wr_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy,
  output logic                     tx
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push, pop;
  logic [7:0]       head, head_mask;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [1:0]       nbits_q, nbits_d;
  logic             par_en_q, par_en_d, par_val_q, par_val_d;
  logic             stop2_q, stop2_d;
  logic [2:0]       bit_q, bit_d;
  logic             brk_rel_q, brk_rel_d;
  logic             tx_q, tx_d;
  logic             tick;

  assign wr_ready   = (level_q != (AW+1)'(DEPTH));
  assign push       = wr_valid & wr_ready;
  assign fifo_level = level_q;
  assign busy       = (state_q != S_IDLE);
  assign tx         = tx_q;
  assign head       = mem[rd_ptr_q];
  assign tick       = (cnt_q == '0);

  always_comb begin
    case (cfg_bits)
      2'b00:   head_mask = 8'h1F;
      2'b01:   head_mask = 8'h3F;
      2'b10:   head_mask = 8'h7F;
      default: head_mask = 8'hFF;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = tick ? cnt_q : cnt_q - DIV_W'(1);
    div_d     = div_q;
    shreg_d   = shreg_q;
    nbits_d   = nbits_q;
    par_en_d  = par_en_q;
    par_val_d = par_val_q;
    stop2_d   = stop2_q;
    bit_d     = bit_q;
    brk_rel_d = brk_rel_q;
    pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cfg_break) begin
          state_d   = S_BREAK;
          brk_rel_d = 1'b0;
        end else if (level_q != '0) begin
          pop = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          cnt_d   = div_q;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_d   = div_q;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == ({1'b0, nbits_q} + 3'd4)) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          cnt_d   = div_q;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        // bit_q marks the second stop bit when two are configured
        if (tick) begin
          if (stop2_q && (bit_q == '0)) begin
            bit_d = 3'd1;
            cnt_d = div_q;
          end else if ((level_q != '0) && !cfg_break) begin
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        // Low while requested, then one high bit time at the live divisor
        if (!brk_rel_q) begin
          if (!cfg_break) begin
            brk_rel_d = 1'b1;
            cnt_d     = baud_div;
          end
        end else if (tick) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      state_d   = S_START;
      shreg_d   = head;
      nbits_d   = cfg_bits;
      par_en_d  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
      par_val_d = cfg_parity[1] ^ (^(head & head_mask));
      stop2_d   = cfg_stop2;
      div_d     = baud_div;
      cnt_d     = baud_div;
    end
  end

  always_comb begin
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_q[0];
      S_PARITY: tx_d = par_val_q;
      S_BREAK:  tx_d = brk_rel_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      shreg_q   <= '0;
      nbits_q   <= '0;
      par_en_q  <= 1'b0;
      par_val_q <= 1'b0;
      stop2_q   <= 1'b0;
      bit_q     <= '0;
      brk_rel_q <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shreg_q   <= shreg_d;
      nbits_q   <= nbits_d;
      par_en_q  <= par_en_d;
      par_val_q <= par_val_d;
      stop2_q   <= stop2_d;
      bit_q     <= bit_d;
      brk_rel_q <= brk_rel_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: expected line waveforms are built from frame rules
// (start, N data bits LSB first, optional parity, stop bits) and compared per clock.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic [DIV_W-1:0] baud_div = '0;
  logic [1:0]       cfg_bits = '0;
  logic [1:0]       cfg_parity = '0;
  logic             cfg_stop2 = 1'b0;
  logic             cfg_break = 1'b0;
  logic             wr_valid = 1'b0;
  logic [7:0]       wr_data = '0;
  logic             wr_ready;
  logic [4:0]       fifo_level;
  logic             busy;
  logic             tx;

  int vectors = 0;
  int miscompares = 0;
  bit frame_bits[$];

  uart_tx_fifo #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .nrst(nrst), .baud_div(baud_div), .cfg_bits(cfg_bits),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .cfg_break(cfg_break),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .fifo_level(fifo_level), .busy(busy), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  task automatic set_cfg(input int div, input logic [1:0] nb, input logic [1:0] par, input logic st2);
    baud_div   = DIV_W'(div);
    cfg_bits   = nb;
    cfg_parity = par;
    cfg_stop2  = st2;
  endtask

  // Reference frame: 0, N data bits LSB first, parity (even=XOR, odd=~XOR), stop bit(s)
  task automatic build_frame(input logic [7:0] b, input logic [1:0] nb, input logic [1:0] par, input logic st2);
    int n;
    bit p;
    n = 5 + int'(nb);
    p = 1'b0;
    frame_bits.delete();
    frame_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      frame_bits.push_back(b[i]);
      p = p ^ b[i];
    end
    if (par == 2'd1) frame_bits.push_back(p);
    else if (par == 2'd2) frame_bits.push_back(~p);
    frame_bits.push_back(1'b1);
    if (st2) frame_bits.push_back(1'b1);
  endtask

  // One frame from idle/empty: checks latency, every tx clock, busy window and level.
  task automatic single(input logic [7:0] b, input int div, input logic [1:0] nb,
                        input logic [1:0] par, input logic st2, input logic scramble);
    int len;
    logic etx, ebusy;
    set_cfg(div, nb, par, st2);
    build_frame(b, nb, par, st2);
    len = frame_bits.size() * (div + 1);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = b;
    @(posedge clk);
    #1 wr_valid = 1'b0;
    for (int k = 0; k <= len + 3; k++) begin
      @(negedge clk);
      etx   = (k >= 2 && (k - 2) < len) ? frame_bits[(k - 2) / (div + 1)] : 1'b1;
      ebusy = (k >= 1 && k <= len);
      chk("tx", k, 32'(tx), 32'(etx));
      chk("busy", k, 32'(busy), 32'(ebusy));
      if (k == 0) chk("level_after_push", k, 32'(fifo_level), 32'd1);
      if (k == 1) chk("level_after_pop", k, 32'(fifo_level), 32'd0);
      // Config changes after the frame is latched must not disturb it
      if (scramble && k == 3) begin
        baud_div   = DIV_W'($urandom_range(0, 7));
        cfg_bits   = 2'($urandom_range(0, 3));
        cfg_parity = 2'($urandom_range(0, 3));
        cfg_stop2  = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // Checks one frame starting at the negedge of its first start-bit clock;
  // leaves off at the negedge just after its last stop clock.
  task automatic frame_at(input logic [7:0] b, input int div, input logic [1:0] nb,
                          input logic [1:0] par, input logic st2, input string tag);
    build_frame(b, nb, par, st2);
    for (int j = 0; j < frame_bits.size(); j++) begin
      for (int c = 0; c <= div; c++) begin
        chk(tag, j, 32'(tx), 32'(frame_bits[j]));
        @(negedge clk);
      end
    end
  endtask

  initial begin
    bit found;

    // Reset state
    #12;
    chk("rst_tx", 0, 32'(tx), 32'd1);
    chk("rst_busy", 0, 32'(busy), 32'd0);
    chk("rst_wr_ready", 0, 32'(wr_ready), 32'd1);
    chk("rst_level", 0, 32'(fifo_level), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed frames
    single(8'h55, 3, 2'b11, 2'b00, 1'b0, 1'b0);
    single(8'h13, 0, 2'b00, 2'b01, 1'b0, 1'b0);
    single(8'h7F, 2, 2'b10, 2'b10, 1'b1, 1'b0);
    single(8'hE0, 1, 2'b00, 2'b11, 1'b0, 1'b0);

    // Randomised frames with mid-frame config churn
    for (int r = 0; r < 12; r++) begin
      single(8'($urandom), $urandom_range(0, 3), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
    end

    // Fill FIFO while the line is held in break, then drain back-to-back
    set_cfg(1, 2'b11, 2'b00, 1'b0);
    cfg_break = 1'b1;
    repeat (3) @(negedge clk);
    chk("fill_break_tx", 0, 32'(tx), 32'd0);
    chk("fill_break_busy", 0, 32'(busy), 32'd1);
    for (int i = 0; i <= DEPTH; i++) begin
      chk("fill_wr_ready", i, 32'(wr_ready), (i < DEPTH) ? 32'd1 : 32'd0);
      chk("fill_level", i, 32'(fifo_level), (i < DEPTH) ? 32'(i) : 32'(DEPTH));
      wr_valid = 1'b1;
      wr_data  = 8'(8'hA0 + i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("fill_level_held", 0, 32'(fifo_level), 32'(DEPTH));
    chk("fill_wr_ready_held", 0, 32'(wr_ready), 32'd0);
    cfg_break = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (tx == 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    chk("fill_release_high", 0, 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (tx == 1'b0) found = 1'b1;
      else @(negedge clk);
    end
    chk("fill_first_start", 0, 32'(found), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      frame_at(8'(8'hA0 + i), 1, 2'b11, 2'b00, 1'b0, "fill_frame_tx");
    end
    repeat (2) @(negedge clk);
    chk("fill_done_tx", 0, 32'(tx), 32'd1);
    chk("fill_done_busy", 0, 32'(busy), 32'd0);
    chk("fill_done_level", 0, 32'(fifo_level), 32'd0);

    // Break requested mid-frame: frame completes, then low, then one high bit time
    set_cfg(2, 2'b11, 2'b00, 1'b0);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = 8'hC3;
    @(posedge clk);
    #1 wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    fork
      frame_at(8'hC3, 2, 2'b11, 2'b00, 1'b0, "brk_frame_tx");
      begin
        repeat (5) @(posedge clk);
        #1 cfg_break = 1'b1;
      end
    join
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      if (tx == 1'b0) found = 1'b1;
      else @(negedge clk);
    end
    chk("brk_low_seen", 0, 32'(found), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("brk_hold_tx", i, 32'(tx), 32'd0);
      chk("brk_hold_busy", i, 32'(busy), 32'd1);
    end
    cfg_break = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      chk("brk_rel_busy", k, 32'(busy), (k <= 2) ? 32'd1 : 32'd0);
      if (k >= 1) chk("brk_rel_tx", k, 32'(tx), 32'd1);
    end
    repeat (2) @(negedge clk);
    chk("brk_idle_tx", 0, 32'(tx), 32'd1);
    chk("brk_idle_busy", 0, 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a data bit
    set_cfg(3, 2'b11, 2'b00, 1'b0);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = 8'h00;
    @(negedge clk);
    wr_data  = 8'h33;
    @(negedge clk);
    wr_data  = 8'h5A;
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 chk("pre_rst_tx", 0, 32'(tx), 32'd0);
    #1 nrst = 1'b0;
    #1;
    chk("arst_tx", 0, 32'(tx), 32'd1);
    chk("arst_level", 0, 32'(fifo_level), 32'd0);
    chk("arst_busy", 0, 32'(busy), 32'd0);
    chk("arst_wr_ready", 0, 32'(wr_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    single(8'hA5, 1, 2'b11, 2'b01, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
